// File: rtl/car_motion_sim.sv
// Behavioural car/shaft plant: turns direction/door commands into start delay, per-floor travel
// and level-transit/floor feedback. Define LEVEL_HOLD_EN for a level-style level_trans.
module car_motion_sim #(
  parameter int unsigned FLOORS     = 4,
  parameter int unsigned START_CYC  = 10,
  parameter int unsigned TRAVEL_CYC = 100,
  parameter int unsigned CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        direct,
  input  logic              door,
  output logic              level_trans,
  output logic [FLOORS-1:0] car_floor,
  output logic              moving,
  output logic [1:0]        dir_out,
  output logic              fault
);

  typedef enum logic [1:0] {StIdle, StStart, StTravel, StFault} state_e;

  localparam logic [1:0] DirNone = 2'b00;
  localparam logic [1:0] DirUp   = 2'b01;
  localparam logic [1:0] DirDn   = 2'b10;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FLOORS-1:0] floor_q, floor_d;
  logic [1:0]        dir_q, dir_d;
  logic              moving_q, moving_d;
  logic              fault_q, fault_d;
  logic              level_q, level_d;

  logic [1:0]        cmd_dir;
  logic              floor_bad;
  logic              at_top, at_bot;
  logic [FLOORS-1:0] floor_next;
  logic              next_exists;
  logic              pulse;

  always_comb begin
    if (direct == 3'b001)      cmd_dir = DirUp;
    else if (direct == 3'b010) cmd_dir = DirDn;
    else                       cmd_dir = DirNone;
  end

  // Anything other than exactly one set bit means the floor register got corrupted.
  assign floor_bad = (floor_q == '0) || ((floor_q & (floor_q - FLOORS'(1))) != '0);
  assign at_top    = floor_q[FLOORS-1];
  assign at_bot    = floor_q[0];

  always_comb begin
    floor_next  = floor_q;
    next_exists = 1'b0;
    if (dir_q == DirUp) begin
      floor_next  = floor_q << 1;
      next_exists = ~floor_next[FLOORS-1];
    end else if (dir_q == DirDn) begin
      floor_next  = floor_q >> 1;
      next_exists = ~floor_next[0];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    floor_d  = floor_q;
    dir_d    = dir_q;
    moving_d = moving_q;
    fault_d  = fault_q;
    pulse    = 1'b0;

    case (state_q)
      StIdle: begin
        if (floor_bad) begin
          state_d = StFault;
        end else if (!door && ((cmd_dir == DirUp && !at_top) ||
                               (cmd_dir == DirDn && !at_bot))) begin
          state_d = StStart;
          dir_d   = cmd_dir;
          cnt_d   = CNT_W'(START_CYC);
        end
      end
      StStart: begin
        if (floor_bad) begin
          state_d = StFault;
        end else if (door || cmd_dir != dir_q) begin
          state_d = StIdle;
          dir_d   = DirNone;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d  = StTravel;
          moving_d = 1'b1;
          cnt_d    = CNT_W'(TRAVEL_CYC - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StTravel: begin
        if (floor_bad || door) begin
          state_d = StFault;
        end else if (cnt_q == '0) begin
          // Segment always completes; only then is the command re-examined.
          floor_d = floor_next;
          pulse   = 1'b1;
          if (cmd_dir == dir_q && next_exists) begin
            cnt_d = CNT_W'(TRAVEL_CYC - 1);
          end else begin
            state_d  = StIdle;
            moving_d = 1'b0;
            dir_d    = DirNone;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: ;
    endcase

    if (state_d == StFault) begin
      fault_d  = 1'b1;
      moving_d = 1'b0;
      dir_d    = DirNone;
      cnt_d    = '0;
      floor_d  = floor_q;
      pulse    = 1'b0;
    end
  end

`ifdef LEVEL_HOLD_EN
  always_comb begin
    if (state_d == StFault) begin
      // A fault raised mid-segment leaves the car between landings.
      level_d = (state_q == StFault) ? level_q : (state_q != StTravel);
    end else begin
      level_d = pulse || (state_d != StTravel);
    end
  end
`else
  always_comb level_d = pulse;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      floor_q  <= FLOORS'(1);
      dir_q    <= DirNone;
      moving_q <= 1'b0;
      fault_q  <= 1'b0;
      level_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      floor_q  <= floor_d;
      dir_q    <= dir_d;
      moving_q <= moving_d;
      fault_q  <= fault_d;
      level_q  <= level_d;
    end
  end

  assign level_trans = level_q;
  assign car_floor   = floor_q;
  assign moving      = moving_q;
  assign dir_out     = dir_q;
  assign fault       = fault_q;

endmodule
